count_display_scan: RTL and testbench

//  Consumes the two 4-bit outputs of the dual binary counter stage and drives a two-digit

---
 rtl/count_display_scan_pkg.sv | 26 ++
 rtl/count_display_scan_if.sv | 23 ++
 rtl/count_display_scan_hex7seg_decode.sv | 14 +
 rtl/count_display_scan.sv | 154 +++++++++++++++
 tb/tb_count_display_scan.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_display_scan_pkg.sv
// rtl/count_display_scan_pkg.sv - shared scan states and 7-segment font for count_display_scan
package count_display_scan_pkg;

  // Scan order is SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0
  typedef enum logic [1:0] {
    SHOW0 = 2'd0,
    GAP0  = 2'd1,
    SHOW1 = 2'd2,
    GAP1  = 2'd3
  } scan_state_t;

  // Hex font {g,f,e,d,c,b,a}, 1 = lit; index 15 is the leftmost entry
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Logical all-segments-off pattern including dp
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Digit enable patterns
  localparam logic [1:0] DIG_NONE = 2'b00;
  localparam logic [1:0] DIG_A    = 2'b01;
  localparam logic [1:0] DIG_B    = 2'b10;

endpackage

// File: rtl/count_display_scan_if.sv
// rtl/count_display_scan_if.sv - counter inputs and display pin bundle
interface count_display_scan_if;

  logic [3:0] cnt1_i;
  logic [3:0] cnt2_i;
  logic       hold;
  logic       blank;
  logic [7:0] seg_o;
  logic [1:0] dig_o;
  logic       scan_o;

  // master drives the counter values and controls, slave drives the pins
  modport master (
    output cnt1_i, cnt2_i, hold, blank,
    input  seg_o, dig_o, scan_o
  );

  modport slave (
    input  cnt1_i, cnt2_i, hold, blank,
    output seg_o, dig_o, scan_o
  );

endinterface

// File: rtl/count_display_scan_hex7seg_decode.sv
// rtl/count_display_scan_hex7seg_decode.sv - combinational hex digit to 7-segment decoder
module hex7seg_decode
  import count_display_scan_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  // Plain font lookup, no registers
  always_comb begin
    seg = SEG_FONT[val];
  end

endmodule

// File: rtl/count_display_scan.sv
// rtl/count_display_scan.sv - resync, filter and two-digit multiplexed 7-segment scan of counter values
module count_display_scan
  import count_display_scan_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter int GAP_CYC    = 16,
  parameter int STABLE_CYC = 3,
  parameter int ACTIVE_LOW = 0
) (
  input logic                 clk,
  input logic                 clr1,
  count_display_scan_if.slave bus
);

  localparam int DIV = CLK_HZ / (2 * SCAN_HZ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = (STABLE_CYC > 0) ? $clog2(STABLE_CYC + 1) : 1;

  localparam logic [PW-1:0] SHOW_LAST  = PW'(DIV - GAP_CYC - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYC - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYC);
  localparam logic          POL        = (ACTIVE_LOW != 0);

  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    filt;
  logic [7:0]    disp;
  logic [SW-1:0] stab;
  logic [SW-1:0] stab_nxt;

  scan_state_t   state;
  logic [PW-1:0] cnt;
  logic [7:0]    seg_r;
  logic [1:0]    dig_r;
  logic          scan_r;

  logic [6:0]    dec0;
  logic [6:0]    dec1;
  logic [7:0]    lit0;
  logic [7:0]    lit1;

  // Stability count: a difference across the second sync stage restarts it, otherwise it saturates
  always_comb begin
    stab_nxt = stab;
    if (sync1 != sync2) begin
      stab_nxt = '0;
    end else if (stab != STABLE_MAX) begin
      stab_nxt = stab + 1'b1;
    end
  end

  // Input path: 2-flop synchroniser, de-glitch filter and hold-able display register
  always_ff @(posedge clk or posedge clr1) begin
    if (clr1) begin
      sync1 <= '0;
      sync2 <= '0;
      stab  <= '0;
      filt  <= '0;
      disp  <= '0;
    end else begin
      sync1 <= {bus.cnt2_i, bus.cnt1_i};
      sync2 <= sync1;
      stab  <= stab_nxt;
      if ((stab_nxt == STABLE_MAX) && (stab != STABLE_MAX)) begin
        filt <= sync2;
      end
      if (!bus.hold) begin
        disp <= filt;
      end
    end
  end

  hex7seg_decode u_dec0 (
    .val (disp[3:0]),
    .seg (dec0)
  );

  hex7seg_decode u_dec1 (
    .val (disp[7:4]),
    .seg (dec1)
  );

  // Segment pattern for each digit after blanking; dp is never lit
  always_comb begin
    lit0 = bus.blank ? SEG_OFF : {1'b0, dec0};
    lit1 = bus.blank ? SEG_OFF : {1'b0, dec1};
  end

  // Scan FSM: outputs are loaded on the same edge as the state so pins and state move together
  always_ff @(posedge clk or posedge clr1) begin
    if (clr1) begin
      state  <= GAP1;
      cnt    <= '0;
      seg_r  <= SEG_OFF;
      dig_r  <= DIG_NONE;
      scan_r <= 1'b0;
    end else begin
      scan_r <= 1'b0;
      case (state)
        SHOW0: begin
          if (cnt == SHOW_LAST) begin
            state <= GAP0;
            cnt   <= '0;
            dig_r <= DIG_NONE;
            seg_r <= SEG_OFF;
          end else begin
            cnt   <= cnt + 1'b1;
            seg_r <= lit0;
          end
        end
        GAP0: begin
          if (cnt == GAP_LAST) begin
            state  <= SHOW1;
            cnt    <= '0;
            dig_r  <= DIG_B;
            seg_r  <= lit1;
            scan_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW1: begin
          if (cnt == SHOW_LAST) begin
            state <= GAP1;
            cnt   <= '0;
            dig_r <= DIG_NONE;
            seg_r <= SEG_OFF;
          end else begin
            cnt   <= cnt + 1'b1;
            seg_r <= lit1;
          end
        end
        default: begin
          if (cnt == GAP_LAST) begin
            state  <= SHOW0;
            cnt    <= '0;
            dig_r  <= DIG_A;
            seg_r  <= lit0;
            scan_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Pin polarity is a fixed inversion of the registered values
  assign bus.seg_o  = seg_r ^ {8{POL}};
  assign bus.dig_o  = dig_r ^ {2{POL}};
  assign bus.scan_o = scan_r;

endmodule

// File: tb/tb_count_display_scan.sv
// tb/tb_count_display_scan.sv - directed self-checking bench for count_display_scan
module tb_count_display_scan;

  logic clk = 1'b0;
  logic clr1;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  count_display_scan_if bus_a ();
  count_display_scan_if bus_b ();

  assign bus_b.cnt1_i = bus_a.cnt1_i;
  assign bus_b.cnt2_i = bus_a.cnt2_i;
  assign bus_b.hold   = bus_a.hold;
  assign bus_b.blank  = bus_a.blank;

  count_display_scan #(
    .CLK_HZ(1000), .SCAN_HZ(50), .GAP_CYC(2), .STABLE_CYC(3), .ACTIVE_LOW(0)
  ) dut_a (
    .clk  (clk),
    .clr1 (clr1),
    .bus  (bus_a)
  );

  count_display_scan #(
    .CLK_HZ(1000), .SCAN_HZ(50), .GAP_CYC(2), .STABLE_CYC(3), .ACTIVE_LOW(1)
  ) dut_b (
    .clk  (clk),
    .clr1 (clr1),
    .bus  (bus_b)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [1:0] exp_dig(input int k);
    int m;
    m = k % 20;
    if (m < 8)       return 2'b01;
    else if (m < 10) return 2'b00;
    else if (m < 18) return 2'b10;
    else             return 2'b00;
  endfunction

  // Returns at the sample where a SHOW state with the wanted digit has just begun
  task automatic sync_show(input logic [1:0] want);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus_a.scan_o === 1'b1 && bus_a.dig_o === want) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL sync_show: no scan pulse for dig %b within 60 cycles", want);
    end
  endtask

  task automatic test_reset();
    logic [1:0] ed;
    logic [7:0] es;
    bus_a.cnt1_i = 4'h0;
    bus_a.cnt2_i = 4'h0;
    bus_a.hold   = 1'b0;
    bus_a.blank  = 1'b0;
    clr1 = 1'b1;
    tick(2);
    checks++;
    if (bus_a.seg_o !== 8'h00 || bus_a.dig_o !== 2'b00 || bus_a.scan_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: seg=%h dig=%b scan=%b, need 00 00 0", bus_a.seg_o, bus_a.dig_o, bus_a.scan_o);
    end
    checks++;
    if (bus_b.seg_o !== 8'hFF || bus_b.dig_o !== 2'b11) begin
      errors++;
      $display("FAIL reset_pins_low: seg=%h dig=%b, need ff 11", bus_b.seg_o, bus_b.dig_o);
    end
    clr1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ed = (k == 1) ? 2'b00 : exp_dig(k - 2);
      es = (ed == 2'b00) ? 8'h00 : 8'h3F;
      checks++;
      if (bus_a.dig_o !== ed || bus_a.seg_o !== es) begin
        errors++;
        $display("FAIL reset_seq k=%0d: dig=%b seg=%h, need dig=%b seg=%h", k, bus_a.dig_o, bus_a.seg_o, ed, es);
      end
    end
    sync_show(2'b10);
    tick(3);
    #2 clr1 = 1'b1;
    #1;
    checks++;
    if (bus_a.seg_o !== 8'h00 || bus_a.dig_o !== 2'b00 || bus_b.seg_o !== 8'hFF || bus_b.dig_o !== 2'b11) begin
      errors++;
      $display("FAIL async_reset: seg=%h dig=%b low_seg=%h low_dig=%b, need 00 00 ff 11",
               bus_a.seg_o, bus_a.dig_o, bus_b.seg_o, bus_b.dig_o);
    end
    @(negedge clk);
    clr1 = 1'b0;
    tick(1);
    checks++;
    if (bus_a.dig_o !== 2'b00) begin
      errors++;
      $display("FAIL restart_gap: dig=%b, need 00", bus_a.dig_o);
    end
    tick(1);
    checks++;
    if (bus_a.dig_o !== 2'b01 || bus_a.scan_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_show0: dig=%b scan=%b, need 01 1", bus_a.dig_o, bus_a.scan_o);
    end
  endtask

  task automatic test_values();
    sync_show(2'b01);
    bus_a.cnt1_i = 4'h5;
    bus_a.cnt2_i = 4'hA;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        checks++;
        if (bus_a.seg_o !== 8'h3F) begin
          errors++;
          $display("FAIL latency_early: seg=%h, need 3f", bus_a.seg_o);
        end
      end
      if (k == 7) begin
        checks++;
        if (bus_a.seg_o !== 8'h6D) begin
          errors++;
          $display("FAIL latency_arrive: seg=%h, need 6d", bus_a.seg_o);
        end
      end
    end
    sync_show(2'b10);
    checks++;
    if (bus_a.seg_o !== 8'h77) begin
      errors++;
      $display("FAIL value_digit1: seg=%h, need 77", bus_a.seg_o);
    end
  endtask

  task automatic test_glitch();
    bit seen8;
    seen8 = 1'b0;
    bus_a.cnt1_i = 4'h7;
    tick(30);
    sync_show(2'b01);
    checks++;
    if (bus_a.seg_o !== 8'h07) begin
      errors++;
      $display("FAIL glitch_start: seg=%h, need 07", bus_a.seg_o);
    end
    bus_a.cnt1_i = 4'hF;
    tick(2);
    bus_a.cnt1_i = 4'h8;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_a.dig_o === 2'b01) begin
        checks++;
        if (bus_a.seg_o !== 8'h07 && bus_a.seg_o !== 8'h7F) begin
          errors++;
          $display("FAIL glitch_value: seg=%h, need 07 or 7f", bus_a.seg_o);
        end else if (seen8 && bus_a.seg_o === 8'h07) begin
          errors++;
          $display("FAIL glitch_order: seg=%h after 8 shown, need 7f", bus_a.seg_o);
        end
        if (bus_a.seg_o === 8'h7F) seen8 = 1'b1;
      end
    end
    checks++;
    if (!seen8) begin
      errors++;
      $display("FAIL glitch_settle: seen8=%b, need 1", seen8);
    end
  endtask

  task automatic test_hold();
    bus_a.cnt1_i = 4'h3;
    tick(30);
    sync_show(2'b01);
    checks++;
    if (bus_a.seg_o !== 8'h4F) begin
      errors++;
      $display("FAIL hold_before: seg=%h, need 4f", bus_a.seg_o);
    end
    bus_a.hold   = 1'b1;
    bus_a.cnt1_i = 4'h9;
    tick(30);
    sync_show(2'b01);
    checks++;
    if (bus_a.seg_o !== 8'h4F) begin
      errors++;
      $display("FAIL hold_frozen: seg=%h, need 4f", bus_a.seg_o);
    end
    bus_a.hold = 1'b0;
    tick(1);
    checks++;
    if (bus_a.seg_o !== 8'h4F) begin
      errors++;
      $display("FAIL hold_release_k1: seg=%h, need 4f", bus_a.seg_o);
    end
    tick(1);
    checks++;
    if (bus_a.seg_o !== 8'h6F) begin
      errors++;
      $display("FAIL hold_release_k2: seg=%h, need 6f", bus_a.seg_o);
    end
  endtask

  task automatic test_blank();
    logic es;
    bus_a.blank = 1'b1;
    sync_show(2'b01);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      es = ((k % 20) == 0) || ((k % 20) == 10);
      checks++;
      if (bus_a.seg_o !== 8'h00 || bus_a.dig_o !== exp_dig(k) || bus_a.scan_o !== es) begin
        errors++;
        $display("FAIL blank k=%0d: seg=%h dig=%b scan=%b, need 00 %b %b",
                 k, bus_a.seg_o, bus_a.dig_o, bus_a.scan_o, exp_dig(k), es);
      end
    end
    bus_a.blank = 1'b0;
    sync_show(2'b01);
    checks++;
    if (bus_a.seg_o !== 8'h6F) begin
      errors++;
      $display("FAIL unblank: seg=%h, need 6f", bus_a.seg_o);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] v;
    logic [7:0] es;
    for (int i = 0; i <= 16; i++) begin
      v = 4'(i);
      es = {1'b0, font[v]};
      bus_a.cnt2_i = v;
      tick(8);
      sync_show(2'b10);
      checks++;
      if (bus_a.seg_o !== es || bus_b.seg_o !== ~es || bus_b.dig_o !== 2'b01) begin
        errors++;
        $display("FAIL wrap v=%h: seg=%h low_seg=%h low_dig=%b, need %h %h 01",
                 v, bus_a.seg_o, bus_b.seg_o, bus_b.dig_o, es, ~es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_glitch();
    test_hold();
    test_blank();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
